input_event_scheduler: RTL and testbench
========================================

INPUT_EVENT_SCHEDULER -- requirements
Module: input_event_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, the number of asynchronous input channels (2..16).
REQ-002 SHALL have parameter STAGES, default 2, the synchronizer flip-flop depth per channel (>=2).
REQ-003 SHALL have parameter DEBOUNCE, default 8, the consecutive stable cycles required to accept a level change (>=1).
REQ-004 SHALL have derived localparam CH_W = max(1, clog2(CHANNELS)).
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port async_in  input  CHANNELS  raw asynchronous channel inputs.
REQ-008 SHALL have port chan_en  input  CHANNELS  per-channel event enable; a disabled channel still debounces but raises no event.
REQ-009 SHALL have port level_o  output  CHANNELS  debounced level per channel.
REQ-010 SHALL have port evt_valid  output  1  event offered.
REQ-011 SHALL have port evt_ready  input  1  consumer accepts the event.
REQ-012 SHALL have port evt_chan  output  CH_W  channel index of the offered event.
REQ-013 SHALL have port evt_level  output  1  new debounced level of that channel (1 = rise, 0 = fall).
REQ-014 SHALL have port overflow_o  output  CHANNELS  sticky per-channel lost-event flags.
REQ-015 SHALL have port clr_overflow  input  1  single-cycle pulse that clears all overflow flags.

Function
REQ-016 SHALL pass each async_in bit through a STAGES-deep synchronizer; the synchronized value s[i] equals async_in[i] sampled STAGES edges earlier.
REQ-017 SHALL count consecutive cycles with s[i] != level_o[i]; the count SHALL clear whenever they are equal, and level_o[i] SHALL toggle on the DEBOUNCE-th consecutive mismatch while the count clears.
REQ-018 SHALL, on a toggle with chan_en[i]=1, set pending[i] and store pend_level[i] = new level.
REQ-019 SHALL, if pending[i] is already set and is not being granted in that cycle, overwrite pend_level[i] with the newer level and set overflow_o[i].
REQ-020 SHALL implement the arbiter FSM with state IDLE (evt_valid=0) and state OFFER (evt_valid=1).
REQ-021 SHALL, in IDLE with any pending bit set, grant the first pending channel in round-robin order starting at last_grant+1 (mod CHANNELS), load evt_chan/evt_level, clear that pending bit, update last_grant, and enter OFFER at the next edge.
REQ-022 SHALL, in OFFER with evt_ready=0, hold evt_chan and evt_level unchanged.
REQ-023 SHALL, in OFFER with evt_ready=1, perform the REQ-021 grant in the same cycle if any bit is pending (back-to-back, no bubble), else return to IDLE.
REQ-024 SHALL, when a channel toggles in the same cycle it is granted, keep pending set with the new level and not set overflow.
REQ-025 SHALL give precedence to a REQ-019 set over clr_overflow in the same cycle.
REQ-026 SHALL, for an idle scheduler, assert evt_valid STAGES+DEBOUNCE+1 edges after the edge that first samples a stable async_in change (11 with defaults).
REQ-027 SHALL, on a chan_en falling edge, leave an already-pending event for that channel pending.

Reset
REQ-028 SHALL, while rstn=0 at a clock edge, clear synchronizer stages, debounce counters, level_o, pending, pend_level, overflow_o, evt_valid, evt_chan and evt_level to 0, and set last_grant = CHANNELS-1 (so channel 0 is first).
REQ-029 SHALL, on reset asserted mid-offer, drop the offered event with no later replay.
REQ-030 SHALL use no asynchronous reset anywhere.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE, OFFER), the CH_W helper function and default parameter constants in shared package input_event_pkg.
REQ-032 SHALL implement the synchronizer as sub-module sync_chain (WIDTH, STAGES; synchronous active-low rstn), instantiated once at width CHANNELS.

Verification
REQ-033 SHALL verify: async_in[0] 0->1 held, all enabled, evt_ready=1 -> evt_valid at edge 11, evt_chan=0, evt_level=1, level_o[0]=1.
REQ-034 SHALL verify: a 5-cycle glitch on async_in[1] -> no level_o change and no event.
REQ-035 SHALL verify: channels 0 and 2 toggle in the same cycle, evt_ready=1 -> events ch0 then ch2 on consecutive cycles; a later ch0+ch2 toggle gives ch2 first? no: ch0 then ch2 again per rotation from last_grant=2.
REQ-036 SHALL verify: evt_ready=0 while ch3 rises then falls (>= DEBOUNCE each) -> single pending ch3 event with evt_level=0 and overflow_o[3]=1; clr_overflow pulse clears it.
REQ-037 SHALL verify: evt_ready=0 during OFFER for 20 cycles -> evt_chan and evt_level stable; evt_ready=1 then accepts exactly one event.
REQ-038 SHALL verify: rstn=0 for one edge during OFFER -> evt_valid=0, level_o=0 and overflow_o=0 at the next edge.

Source files
------------

// File: rtl/input_event_pkg.sv
// Shared definitions for the input event scheduler: arbiter state encoding,
// default parameter values and the channel-index width helper.
package input_event_pkg;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_STAGES   = 2;
   localparam int DEF_DEBOUNCE = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bank; q is d delayed by STAGES clock edges.
module sync_chain #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_reg [STAGES];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/input_event_scheduler.sv
// Synchronizes and debounces asynchronous inputs, queues one pending level
// change per channel and offers them round-robin over a valid/ready port.
module input_event_scheduler
   import input_event_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int STAGES   = DEF_STAGES,
   parameter int DEBOUNCE = DEF_DEBOUNCE,
   localparam int CH_W    = ch_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [CHANNELS-1:0] async_in,
   input  logic [CHANNELS-1:0] chan_en,
   output logic [CHANNELS-1:0] level_o,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [CH_W-1:0]     evt_chan,
   output logic                evt_level,
   output logic [CHANNELS-1:0] overflow_o,
   input  logic                clr_overflow
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   logic [CHANNELS-1:0] sync_s;
   logic [CHANNELS-1:0] level_vec;
   logic [CHANNELS-1:0] toggle;
   logic [CHANNELS-1:0] pending_vec;
   logic [CHANNELS-1:0] pend_level_vec;
   logic [CHANNELS-1:0] overflow_vec;
   logic [CHANNELS-1:0] grant_oh;

   arb_state_t      state_reg, state_next;
   logic [CH_W-1:0] evt_chan_reg, evt_chan_next;
   logic            evt_level_reg, evt_level_next;
   logic [CH_W-1:0] last_grant_reg, last_grant_next;
   logic            do_grant;
   logic            found;
   logic [CH_W-1:0] sel;

   sync_chain #(
      .WIDTH  (CHANNELS),
      .STAGES (STAGES)
   ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (async_in),
      .q    (sync_s)
   );

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNT_W-1:0] count_reg;
      logic             level_reg;
      logic             pending_reg;
      logic             pend_level_reg;
      logic             overflow_reg;
      logic             mismatch;

      assign mismatch   = sync_s[gi] ^ level_reg;
      assign toggle[gi] = mismatch && (count_reg == CNT_W'(DEBOUNCE - 1));

      always_ff @(posedge clk) begin
         if (!rstn) begin
            count_reg      <= '0;
            level_reg      <= 1'b0;
            pending_reg    <= 1'b0;
            pend_level_reg <= 1'b0;
            overflow_reg   <= 1'b0;
         end else begin
            if (!mismatch || toggle[gi]) begin
               count_reg <= '0;
            end else begin
               count_reg <= count_reg + 1'b1;
            end
            if (toggle[gi]) begin
               level_reg <= ~level_reg;
            end
            // A fresh toggle wins over a grant in the same cycle; only a
            // still-waiting older event counts as lost.
            if (toggle[gi] && chan_en[gi]) begin
               pending_reg    <= 1'b1;
               pend_level_reg <= ~level_reg;
               if (pending_reg && !grant_oh[gi]) begin
                  overflow_reg <= 1'b1;
               end else if (clr_overflow) begin
                  overflow_reg <= 1'b0;
               end
            end else begin
               if (grant_oh[gi]) begin
                  pending_reg <= 1'b0;
               end
               if (clr_overflow) begin
                  overflow_reg <= 1'b0;
               end
            end
         end
      end

      assign level_vec[gi]      = level_reg;
      assign pending_vec[gi]    = pending_reg;
      assign pend_level_vec[gi] = pend_level_reg;
      assign overflow_vec[gi]   = overflow_reg;
   end

   // Round-robin pick: lowest pending index above last_grant, else wrap.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!found && pending_vec[i] && (i > int'(last_grant_reg))) begin
            found = 1'b1;
            sel   = CH_W'(i);
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (!found && pending_vec[i]) begin
            found = 1'b1;
            sel   = CH_W'(i);
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      evt_chan_next   = evt_chan_reg;
      evt_level_next  = evt_level_reg;
      last_grant_next = last_grant_reg;
      grant_oh        = '0;
      do_grant        = (state_reg == IDLE) || evt_ready;
      if (do_grant) begin
         if (found) begin
            grant_oh[sel]   = 1'b1;
            evt_chan_next   = sel;
            evt_level_next  = pend_level_vec[sel];
            last_grant_next = sel;
            state_next      = OFFER;
         end else begin
            state_next = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         evt_chan_reg   <= '0;
         evt_level_reg  <= 1'b0;
         last_grant_reg <= CH_W'(CHANNELS - 1);
      end else begin
         state_reg      <= state_next;
         evt_chan_reg   <= evt_chan_next;
         evt_level_reg  <= evt_level_next;
         last_grant_reg <= last_grant_next;
      end
   end

   assign level_o    = level_vec;
   assign overflow_o = overflow_vec;
   assign evt_valid  = (state_reg == OFFER);
   assign evt_chan   = evt_chan_reg;
   assign evt_level  = evt_level_reg;

endmodule

// File: tb/tb_input_event_scheduler.sv
// Directed bench for input_event_scheduler with default parameters.
module tb_input_event_scheduler;

   logic       clk = 1'b0;
   logic       rstn;
   logic [3:0] async_in;
   logic [3:0] chan_en;
   logic [3:0] level_o;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_chan;
   logic       evt_level;
   logic [3:0] overflow_o;
   logic       clr_overflow;

   int checks = 0;
   int errors = 0;
   logic flag;

   input_event_scheduler dut (
      .clk          (clk),
      .rstn         (rstn),
      .async_in     (async_in),
      .chan_en      (chan_en),
      .level_o      (level_o),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_chan     (evt_chan),
      .evt_level    (evt_level),
      .overflow_o   (overflow_o),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rstn && evt_valid && evt_ready) begin
         $display("txn: accept ch=%0d level=%0d", evt_chan, evt_level);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn = 1'b0; async_in = 4'b0000; chan_en = 4'b1111;
      evt_ready = 1'b0; clr_overflow = 1'b0;
      tick(3);
      check("rst_valid",    32'(evt_valid),  32'h0);
      check("rst_level",    32'(level_o),    32'h0);
      check("rst_overflow", 32'(overflow_o), 32'h0);
      check("rst_chan",     32'(evt_chan),   32'h0);
      check("rst_evtlevel", 32'(evt_level),  32'h0);
      rstn = 1'b1;
      tick(1);

      // ch0 rise with ready=1: level at edge 10, offer at edge 11
      evt_ready = 1'b1;
      async_in  = 4'b0001;
      tick(9);
      check("ch0_level_e9",  32'(level_o),   32'h0);
      tick(1);
      check("ch0_level_e10", 32'(level_o),   32'h1);
      check("ch0_valid_e10", 32'(evt_valid), 32'h0);
      tick(1);
      check("ch0_valid_e11", 32'(evt_valid), 32'h1);
      check("ch0_chan",      32'(evt_chan),  32'h0);
      check("ch0_evtlevel",  32'(evt_level), 32'h1);
      tick(1);
      check("ch0_accepted",  32'(evt_valid), 32'h0);

      // 5-cycle glitch on ch1 must be filtered
      async_in = 4'b0011;
      tick(5);
      async_in = 4'b0001;
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (evt_valid !== 1'b0 || level_o !== 4'b0001) flag = 1'b1;
      end
      check("glitch_no_event", 32'(flag), 32'h0);
      check("glitch_level",    32'(level_o), 32'h1);

      // offer held for 20 cycles with ready=0
      evt_ready = 1'b0;
      async_in  = 4'b0011;
      tick(11);
      check("hold_valid", 32'(evt_valid), 32'h1);
      check("hold_chan",  32'(evt_chan),  32'h1);
      check("hold_level", 32'(evt_level), 32'h1);
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (evt_valid !== 1'b1 || evt_chan !== 2'd1 || evt_level !== 1'b1) flag = 1'b1;
      end
      check("hold_stable", 32'(flag), 32'h0);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("hold_accept_one", 32'(evt_valid), 32'h0);
      tick(5);
      check("hold_no_more", 32'(evt_valid), 32'h0);

      // reset during an offer drops the event
      async_in = 4'b0001;
      tick(11);
      check("rstoffer_valid", 32'(evt_valid), 32'h1);
      check("rstoffer_chan",  32'(evt_chan),  32'h1);
      check("rstoffer_level", 32'(evt_level), 32'h0);
      async_in = 4'b0000;
      rstn = 1'b0;
      tick(1);
      rstn = 1'b1;
      check("rstoffer_valid0", 32'(evt_valid),  32'h0);
      check("rstoffer_lvl0",   32'(level_o),    32'h0);
      check("rstoffer_ovf0",   32'(overflow_o), 32'h0);
      flag = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (evt_valid !== 1'b0) flag = 1'b1;
      end
      check("rstoffer_no_replay", 32'(flag), 32'h0);

      // ch0 and ch2 together, last_grant=3 -> ch0 then ch2 back-to-back
      evt_ready = 1'b1;
      async_in  = 4'b0101;
      tick(10);
      check("pair_level",   32'(level_o),   32'h5);
      check("pair_idle",    32'(evt_valid), 32'h0);
      tick(1);
      check("pair1_chan",   32'({evt_valid, evt_chan, evt_level}), 32'b1001);
      tick(1);
      check("pair1_chan2",  32'({evt_valid, evt_chan, evt_level}), 32'b1101);
      tick(1);
      check("pair1_done",   32'(evt_valid), 32'h0);
      async_in = 4'b0000;
      tick(11);
      check("pair2_chan",   32'({evt_valid, evt_chan, evt_level}), 32'b1000);
      tick(1);
      check("pair2_chan2",  32'({evt_valid, evt_chan, evt_level}), 32'b1100);
      tick(1);
      check("pair2_done",   32'(evt_valid), 32'h0);

      // ch3 rises then falls while ch1 occupies the offer -> overflow
      evt_ready = 1'b0;
      async_in  = 4'b0010;
      tick(11);
      check("ovf_offer_ch1", 32'({evt_valid, evt_chan, evt_level}), 32'b1011);
      async_in = 4'b1010;
      tick(14);
      check("ovf_no_flag_yet", 32'(overflow_o), 32'h0);
      async_in = 4'b0010;
      tick(14);
      check("ovf_flag",      32'(overflow_o), 32'h8);
      check("ovf_level",     32'(level_o),    32'h2);
      check("ovf_hold_ch1",  32'(evt_chan),   32'h1);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      check("ovf_cleared",   32'(overflow_o), 32'h0);
      evt_ready = 1'b1;
      tick(1);
      check("ovf_ch3_evt",   32'({evt_valid, evt_chan, evt_level}), 32'b1110);
      tick(1);
      check("ovf_single",    32'(evt_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
